// File: rtl/d_fifo_drain_pkg.sv
// Shared definitions for the D0/D1 output-FIFO drain stage.
package d_fifo_drain_pkg;

  localparam int unsigned DATA_W = 6;

  // Source tags carried alongside each merged word
  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry FIFO of {dest, data} words sitting between FIFO read capture and the output port.
module drain_skid_buf #(
  parameter int unsigned DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_dest,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_dest,
  output logic [1:0]        occupancy,
  output logic              valid
);

  logic [DATA_W:0] mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      cnt_q;
  logic            do_wr;
  logic            do_rd;

  // Reads only pop a held word; writes are refused when full unless a read frees a slot
  always_comb begin
    do_rd = rd && (cnt_q != 2'd0);
    do_wr = wr && ((cnt_q != 2'd2) || do_rd);
  end

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= {wr_dest, wr_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_rd) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(do_wr) - 2'(do_rd);
    end
  end

  // Head of buffer drives the output directly
  always_comb begin
    {rd_dest, rd_data} = mem_q[rd_ptr_q];
    occupancy          = cnt_q;
    valid              = (cnt_q != 2'd0);
  end

endmodule

// File: rtl/d_fifo_drain.sv
// Merges the D0/D1 output FIFOs into one tagged ready/valid stream with round-robin fairness,
// counts delivered words per source and reports when fully drained.
module d_fifo_drain #(
  parameter int unsigned DATA_W = d_fifo_drain_pkg::DATA_W,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned BUF_D  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty_fifo_D0,
  input  logic              empty_fifo_D1,
  input  logic [DATA_W-1:0] data_out_D0,
  input  logic [DATA_W-1:0] data_out_D1,
  input  logic              out_ready,
  output logic              D0_pop,
  output logic              D1_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              dest_out,
  output logic              valid_out,
  output logic              drain_idle,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1
);

  import d_fifo_drain_pkg::*;

  state_e             state_q, state_d;
  logic               last_grant_q;
  logic               inflight_q;
  logic               dsel_q;
  logic [CNT_W-1:0]   cnt0_q, cnt1_q;

  logic [1:0]         buf_occ;
  logic               buf_valid;
  logic [DATA_W-1:0]  buf_data;
  logic               buf_dest;
  logic               deliver;
  logic [2:0]         occ_eff;
  logic               room;
  logic               elig0, elig1;
  logic               grant;
  logic               pop;

  // Eligibility, space check and round-robin grant
  always_comb begin
    deliver = buf_valid && out_ready;
    // Occupancy as it will be after this cycle's delivery
    occ_eff = {1'b0, buf_occ} - {2'b00, deliver};
    room    = (occ_eff + {2'b00, inflight_q} + 3'd1) <= 3'(BUF_D);
    // A source popped last cycle may still show a stale non-empty flag
    elig0   = !empty_fifo_D0 && !(inflight_q && (dsel_q == DEST_D0));
    elig1   = !empty_fifo_D1 && !(inflight_q && (dsel_q == DEST_D1));
    grant   = DEST_D0;
    if (elig0 && elig1) begin
      grant = ~last_grant_q;
    end else if (elig1) begin
      grant = DEST_D1;
    end
    pop    = (state_q == StRun) && room && (elig0 || elig1);
    D0_pop = pop && (grant == DEST_D0);
    D1_pop = pop && (grant == DEST_D1);
  end

  // Next-state logic; DRAIN exits once nothing is buffered after this cycle and nothing is in flight
  always_comb begin
    state_d    = state_q;
    drain_idle = (state_q == StIdle);
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) state_d = StDrain;
      end
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if ((occ_eff == 3'd0) && !inflight_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, arbitration history and read-capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_grant_q <= DEST_D1;
      inflight_q   <= 1'b0;
      dsel_q       <= DEST_D0;
    end else begin
      state_q    <= state_d;
      inflight_q <= pop;
      dsel_q     <= grant;
      if (pop) begin
        last_grant_q <= grant;
      end
    end
  end

  // Per-source delivery counters, wrapping naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (deliver) begin
      if (buf_dest == DEST_D1) begin
        cnt1_q <= cnt1_q + 1'b1;
      end else begin
        cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  drain_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid_buf (
    .clk       (clk),
    .reset     (reset),
    .wr        (inflight_q),
    .wr_data   (dsel_q ? data_out_D1 : data_out_D0),
    .wr_dest   (dsel_q),
    .rd        (deliver),
    .rd_data   (buf_data),
    .rd_dest   (buf_dest),
    .occupancy (buf_occ),
    .valid     (buf_valid)
  );

  // Output stage is the skid-buffer head
  always_comb begin
    data_out  = buf_data;
    dest_out  = buf_dest;
    valid_out = buf_valid;
    cnt_D0    = cnt0_q;
    cnt_D1    = cnt1_q;
  end

endmodule

// File: tb/tb_d_fifo_drain.sv
// Bench for d_fifo_drain: FIFO source models, scoreboard of expected words, table of load patterns.
module tb_d_fifo_drain;

  localparam int DW = 6;
  localparam int CW = 8;

  typedef struct packed {
    logic          dest;
    logic [DW-1:0] data;
  } word_t;

  typedef struct {
    int            n0;
    int            n1;
    logic [DW-1:0] base0;
    logic [DW-1:0] base1;
    int            stall;
    int            gap;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          empty_fifo_D0, empty_fifo_D1;
  logic [DW-1:0] data_out_D0, data_out_D1;
  logic          out_ready;
  logic          D0_pop, D1_pop;
  logic [DW-1:0] data_out;
  logic          dest_out;
  logic          valid_out;
  logic          drain_idle;
  logic [CW-1:0] cnt_D0, cnt_D1;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  word_t         sb[$];
  int            pop_cyc[$];
  logic [CW-1:0] bcnt0, bcnt1;
  int            cyc;
  int            n_tests = 0;
  int            n_fail  = 0;
  vec_t          vecs[7];

  always #5 clk = ~clk;

  d_fifo_drain #(
    .DATA_W (DW),
    .CNT_W  (CW),
    .BUF_D  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .empty_fifo_D0 (empty_fifo_D0),
    .empty_fifo_D1 (empty_fifo_D1),
    .data_out_D0   (data_out_D0),
    .data_out_D1   (data_out_D1),
    .out_ready     (out_ready),
    .D0_pop        (D0_pop),
    .D1_pop        (D1_pop),
    .data_out      (data_out),
    .dest_out      (dest_out),
    .valid_out     (valid_out),
    .drain_idle    (drain_idle),
    .cnt_D0        (cnt_D0),
    .cnt_D1        (cnt_D1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    sb.delete();
    pop_cyc.delete();
    bcnt0 = '0;
    bcnt1 = '0;
  endtask

  // One clock: sample and score at negedge, update FIFO models just after posedge
  task automatic tick();
    logic [DW-1:0] n0v, n1v;
    logic          g0, g1;
    word_t         w;
    g0 = 1'b0; g1 = 1'b0; n0v = '0; n1v = '0;
    @(negedge clk);
    check("pop_exclusive", 32'(D0_pop & D1_pop), 32'd0);
    check("cnt_D0", 32'(cnt_D0), 32'(bcnt0));
    check("cnt_D1", 32'(cnt_D1), 32'(bcnt1));
    if (valid_out && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_delivery: got 0x%0h dest %0d, expected no word (cycle %0d)",
                 data_out, dest_out, cyc);
      end else begin
        w = sb.pop_front();
        check("data_out", 32'(data_out), 32'(w.data));
        check("dest_out", 32'(dest_out), 32'(w.dest));
        if (w.dest) bcnt1++;
        else        bcnt0++;
      end
    end
    if (D0_pop) begin
      g0 = 1'b1;
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL underflow_D0: got pop, expected none (cycle %0d)", cyc);
      end else n0v = q0.pop_front();
    end
    if (D1_pop) begin
      g1 = 1'b1;
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL underflow_D1: got pop, expected none (cycle %0d)", cyc);
      end else n1v = q1.pop_front();
    end
    if (D0_pop || D1_pop) pop_cyc.push_back(cyc);
    @(posedge clk);
    #1;
    if (g0) data_out_D0 = n0v;
    if (g1) data_out_D1 = n1v;
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
    cyc++;
  endtask

  // Hold reset, verify reset outputs, release
  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; out_ready = 1'b0;
    empty_fifo_D0 = 1'b1; empty_fifo_D1 = 1'b1;
    data_out_D0 = '0; data_out_D1 = '0;
    clear_model();
    @(posedge clk);
    #1;
    check("rst_D0_pop", 32'(D0_pop), 32'd0);
    check("rst_D1_pop", 32'(D1_pop), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_dest", 32'(dest_out), 32'd0);
    check("rst_idle", 32'(drain_idle), 32'd1);
    check("rst_cnt_D0", 32'(cnt_D0), 32'd0);
    check("rst_cnt_D1", 32'(cnt_D1), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic load(input int n0, input int n1, input logic [DW-1:0] b0,
                      input logic [DW-1:0] b1);
    for (int i = 0; i < n0; i++) q0.push_back(DW'(b0 + i));
    for (int i = 0; i < n1; i++) q1.push_back(DW'(b1 + i));
    empty_fifo_D0 = (q0.size() == 0);
    empty_fifo_D1 = (q1.size() == 0);
  endtask

  // Expected delivery order: alternate while both sources hold words, D0 first
  task automatic expect_merge(input int n0, input int n1, input logic [DW-1:0] b0,
                              input logic [DW-1:0] b1);
    int   i0, i1;
    logic last;
    i0 = 0; i1 = 0; last = 1'b1;
    while (i0 < n0 || i1 < n1) begin
      if (i0 < n0 && (i1 >= n1 || last)) begin
        sb.push_back({1'b0, DW'(b0 + i0)});
        i0++;
        last = 1'b0;
      end else begin
        sb.push_back({1'b1, DW'(b1 + i1)});
        i1++;
        last = 1'b1;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int budget;
    do_reset();
    load(v.n0, v.n1, v.base0, v.base1);
    expect_merge(v.n0, v.n1, v.base0, v.base1);
    enable    = 1'b1;
    out_ready = (v.stall == 0);
    for (int k = 0; k < v.stall; k++) tick();
    if (v.stall > 0) begin
      check($sformatf("v%0d_stall_pops", idx), 32'(pop_cyc.size()), 32'd2);
      check($sformatf("v%0d_stall_valid", idx), 32'(valid_out), 32'd1);
      check($sformatf("v%0d_stall_head", idx), 32'(data_out), 32'(sb[0].data));
      tick();
      check($sformatf("v%0d_stall_hold", idx), 32'(data_out), 32'(sb[0].data));
      out_ready = 1'b1;
    end
    budget = 4 * (v.n0 + v.n1) + 40;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check($sformatf("v%0d_all_delivered", idx), 32'(sb.size()), 32'd0);
    tick();
    check($sformatf("v%0d_pops", idx), 32'(pop_cyc.size()), 32'(v.n0 + v.n1));
    check($sformatf("v%0d_final_cnt_D0", idx), 32'(cnt_D0), 32'(CW'(v.n0)));
    check($sformatf("v%0d_final_cnt_D1", idx), 32'(cnt_D1), 32'(CW'(v.n1)));
    if (v.gap != 0) begin
      for (int i = 1; i < pop_cyc.size(); i++) begin
        check($sformatf("v%0d_pop_gap", idx), 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(v.gap));
      end
    end
    enable = 1'b0;
    budget = 10;
    while (!drain_idle && budget > 0) begin
      tick();
      budget--;
    end
    check($sformatf("v%0d_idle", idx), 32'(drain_idle), 32'd1);
  endtask

  initial begin
    int budget;
    cyc = 0;
    vecs[0] = '{3, 0,   6'h01, 6'h00, 0, 2};
    vecs[1] = '{2, 2,   6'h0A, 6'h2A, 0, 1};
    vecs[2] = '{2, 2,   6'h0A, 6'h2A, 6, 0};
    vecs[3] = '{0, 3,   6'h00, 6'h10, 0, 2};
    vecs[4] = '{3, 1,   6'h20, 6'h30, 0, 0};
    vecs[5] = '{1, 4,   6'h05, 6'h38, 0, 0};
    vecs[6] = '{0, 256, 6'h00, 6'h00, 0, 2};

    // Reset, then idle with both FIFOs empty
    do_reset();
    repeat (3) tick();
    check("t1_idle_disabled", 32'(drain_idle), 32'd1);
    enable = 1'b1;
    repeat (3) tick();
    check("t1_no_pops", 32'(pop_cyc.size()), 32'd0);
    check("t1_valid", 32'(valid_out), 32'd0);
    check("t1_run_not_idle", 32'(drain_idle), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // enable falls with two words buffered; FIFOs still hold more
    do_reset();
    load(2, 2, 6'h0A, 6'h2A);
    sb.push_back({1'b0, 6'h0A});
    sb.push_back({1'b1, 6'h2A});
    enable = 1'b1;
    repeat (4) tick();
    check("t5_pops_before", 32'(pop_cyc.size()), 32'd2);
    enable = 1'b0;
    repeat (2) tick();
    check("t5_buffered_valid", 32'(valid_out), 32'd1);
    out_ready = 1'b1;
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      check("t5_busy", 32'(drain_idle), 32'd0);
      tick();
      budget--;
    end
    check("t5_delivered", 32'(sb.size()), 32'd0);
    check("t5_idle_after_last", 32'(drain_idle), 32'd1);
    check("t5_no_more_pops", 32'(pop_cyc.size()), 32'd2);
    tick();
    check("t5_cnt_D0", 32'(cnt_D0), 32'd1);
    check("t5_cnt_D1", 32'(cnt_D1), 32'd1);

    // Reset while one word sits in the buffer
    do_reset();
    load(0, 1, 6'h00, 6'h15);
    sb.push_back({1'b1, 6'h15});
    enable = 1'b1;
    out_ready = 1'b1;
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    tick();
    check("t7_cnt_before", 32'(cnt_D1), 32'd1);
    out_ready = 1'b0;
    load(1, 0, 6'h07, 6'h00);
    sb.push_back({1'b0, 6'h07});
    budget = 8;
    while (!valid_out && budget > 0) begin
      tick();
      budget--;
    end
    check("t7_buffered", 32'(valid_out), 32'd1);
    reset = 1'b0;
    #1;
    check("t7_valid_cleared", 32'(valid_out), 32'd0);
    check("t7_cnt_D0_cleared", 32'(cnt_D0), 32'd0);
    check("t7_cnt_D1_cleared", 32'(cnt_D1), 32'd0);
    check("t7_idle", 32'(drain_idle), 32'd1);
    clear_model();
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    check("t7_no_redelivery", 32'(valid_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
